// File: rtl/relu_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : relu_vector_sequencer
// Description : Time-multiplexed activation stage for one MLP layer output
//               vector. A full NUM_ELEM vector is accepted in one handshake,
//               activated LANES elements per cycle (ReLU or identity bypass),
//               and returned together with the count of strictly positive
//               output elements.
// Ports       : clk, rst          - clock / synchronous active-high reset
//               in_valid/in_ready - upstream vector handshake (a_in, act_en)
//               act_en            - 1 = ReLU, 0 = identity, sampled on accept
//               a_in              - flat input vector, element j at
//                                   [j*DATA_WIDTH +: DATA_WIDTH]
//               out_valid/out_ready - downstream vector handshake
//               a_out             - registered activated vector (same layout)
//               pos_count         - number of a_out elements > 0
//               busy              - high while a vector is in flight
// Revision    : 1.0 - initial release
// ============================================================================
module relu_vector_sequencer #(
    parameter int  NUM_ELEM   = 8,
    parameter int  LANES      = 2,
    parameter int  DATA_WIDTH = 16,
    localparam int BEATS      = NUM_ELEM / LANES,
    localparam int CNT_W      = $clog2(NUM_ELEM + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           act_en,
    input  logic [NUM_ELEM*DATA_WIDTH-1:0] a_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_ELEM*DATA_WIDTH-1:0] a_out,
    output logic [CNT_W-1:0]               pos_count,
    output logic                           busy
);

    // A single-beat configuration still needs a 1-bit beat register.
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                          r_state;
    logic [BEAT_W-1:0]               r_beat;
    logic                            r_mode;
    logic [NUM_ELEM*DATA_WIDTH-1:0]  r_a_buf;
    logic [NUM_ELEM*DATA_WIDTH-1:0]  r_a_out;
    logic [CNT_W-1:0]                r_pos_count;

    logic [NUM_ELEM*DATA_WIDTH-1:0]  w_res;
    logic [NUM_ELEM-1:0]             w_sel;
    logic [NUM_ELEM-1:0]             w_pos;
    logic [CNT_W-1:0]                w_pos_inc;

    // Per-element activation. Every element is evaluated every cycle; w_sel
    // picks the LANES elements that belong to the current beat. Clamping on
    // the sign bit alone means the most-negative value also maps to zero.
    for (genvar j = 0; j < NUM_ELEM; j++) begin : g_elem
        logic [DATA_WIDTH-1:0] w_x;
        assign w_x = r_a_buf[j*DATA_WIDTH +: DATA_WIDTH];
        assign w_res[j*DATA_WIDTH +: DATA_WIDTH] =
            (r_mode && w_x[DATA_WIDTH-1]) ? '0 : w_x;
        assign w_sel[j] = (BEAT_W'(j / LANES) == r_beat);
        // Strictly positive: sign clear and not zero.
        assign w_pos[j] = w_sel[j]
                        && !w_res[j*DATA_WIDTH + DATA_WIDTH - 1]
                        && (|w_res[j*DATA_WIDTH +: DATA_WIDTH]);
    end

    always_comb begin
        w_pos_inc = '0;
        for (int k = 0; k < NUM_ELEM; k++) begin
            w_pos_inc = w_pos_inc + CNT_W'(w_pos[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_beat      <= '0;
            r_mode      <= 1'b0;
            r_a_buf     <= '0;
            r_a_out     <= '0;
            r_pos_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        // Snapshot vector and mode so later input changes
                        // cannot disturb the vector in flight.
                        r_a_buf     <= a_in;
                        r_mode      <= act_en;
                        r_pos_count <= '0;
                        r_beat      <= '0;
                        r_state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int k = 0; k < NUM_ELEM; k++) begin
                        if (w_sel[k]) begin
                            r_a_out[k*DATA_WIDTH +: DATA_WIDTH] <=
                                w_res[k*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                    r_pos_count <= r_pos_count + w_pos_inc;
                    if (r_beat == BEAT_W'(BEATS - 1)) begin
                        r_beat  <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_beat <= r_beat + BEAT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decode the state register directly.
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign a_out     = r_a_out;
    assign pos_count = r_pos_count;

endmodule
`default_nettype wire

// File: tb/tb_relu_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_relu_vector_sequencer
// Description : Directed self-checking bench for relu_vector_sequencer
//               (NUM_ELEM=8, LANES=2, DATA_WIDTH=16). Element j of a vector
//               table maps to a_in[j*16 +: 16].
// Revision    : 1.0 - initial release
// ============================================================================
module tb_relu_vector_sequencer;

    localparam int NUM_ELEM   = 8;
    localparam int LANES      = 2;
    localparam int DATA_WIDTH = 16;
    localparam int CNT_W      = 4;
    localparam int VW         = NUM_ELEM * DATA_WIDTH;

    typedef int vec_t [NUM_ELEM];

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          act_en;
    logic [VW-1:0] a_in;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] a_out;
    logic [CNT_W-1:0] pos_count;
    logic          busy;

    int n_total = 0;
    int n_bad   = 0;

    relu_vector_sequencer #(
        .NUM_ELEM   (NUM_ELEM),
        .LANES      (LANES),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .act_en    (act_en),
        .a_in      (a_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_out     (a_out),
        .pos_count (pos_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Hand-computed stimulus and expected results.
    vec_t va      = '{-3, 5, 0, -32768, 7, -1, 32767, 2};
    vec_t va_relu = '{ 0, 5, 0,      0, 7,  0, 32767, 2};
    vec_t vb      = '{ 1, -1, 2, -2, -32768, 100, 0, -7};
    vec_t vb_relu = '{ 1,  0, 2,  0,      0, 100, 0,  0};
    vec_t vc      = '{ 1, -1, 2, -2, 3, -3, 4, -4};
    vec_t vc_relu = '{ 1,  0, 2,  0, 3,  0, 4,  0};

    function automatic logic [VW-1:0] pack(input vec_t v);
        logic [VW-1:0] r;
        r = '0;
        for (int j = 0; j < NUM_ELEM; j++) begin
            r[j*DATA_WIDTH +: DATA_WIDTH] = 16'(v[j]);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [VW-1:0] got,
                         input logic [VW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one vector, accept it, scramble the inputs, then wait (bounded)
    // for out_valid. Leaves the DUT in DONE; lat = edges after the accept edge.
    task automatic run_vector(input vec_t v, input logic mode,
                              output logic [VW-1:0] res,
                              output logic [CNT_W-1:0] pos, output int lat);
        a_in     = pack(v);
        act_en   = mode;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a_in     = ~pack(v);
        act_en   = ~mode;
        lat      = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        res = a_out;
        pos = pos_count;
    endtask

    task automatic release_output();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [VW-1:0]    res;
        logic [VW-1:0]    held;
        logic [CNT_W-1:0] pos;
        int               lat;
        logic             seen;
        int               n_acc, n_out, gap;
        logic             acc, cap;
        logic [VW-1:0]    cap_a [2];
        logic [CNT_W-1:0] cap_p [2];

        rst = 1'b1; in_valid = 1'b0; act_en = 1'b0; a_in = '0; out_ready = 1'b0;

        // ---------------- reset ----------------
        tick(); tick();
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_a_out", a_out, 0);
        check("rst_pos_count", pos_count, 0);

        // ---------------- ReLU + backpressure ----------------
        run_vector(va, 1'b1, res, pos, lat);
        check("relu_latency", lat, 4);
        check("relu_a_out", res, pack(va_relu));
        check("relu_pos_count", pos, 4);
        held     = pack(va_relu);
        a_in     = pack(vb);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", out_valid, 1);
            check("bp_a_out", a_out, held);
            check("bp_pos_count", pos_count, 4);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        release_output();
        check("drain_out_valid", out_valid, 0);
        check("drain_in_ready", in_ready, 1);
        check("drain_busy", busy, 0);
        check("drain_a_out", a_out, held);

        // ---------------- identity bypass ----------------
        run_vector(va, 1'b0, res, pos, lat);
        check("byp_latency", lat, 4);
        check("byp_a_out", res, pack(va));
        check("byp_pos_count", pos, 4);
        release_output();

        // ---------------- back-to-back ----------------
        a_in = pack(va); act_en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        n_acc = 0; n_out = 0; gap = 0;
        for (int c = 0; c < 40 && n_out < 2; c++) begin
            acc = in_valid && in_ready;
            cap = out_valid && out_ready;
            if (n_acc == 1 && !in_ready) gap++;
            if (cap) begin
                cap_a[n_out] = a_out;
                cap_p[n_out] = pos_count;
            end
            tick();
            if (cap) n_out++;
            if (acc) begin
                n_acc++;
                if (n_acc == 1) a_in = pack(vb);
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_accepts", n_acc, 2);
        check("b2b_outputs", n_out, 2);
        check("b2b_busy_gap", gap, 5);
        if (n_out == 2) begin
            check("b2b_a_out0", cap_a[0], pack(va_relu));
            check("b2b_pos0", cap_p[0], 4);
            check("b2b_a_out1", cap_a[1], pack(vb_relu));
            check("b2b_pos1", cap_p[1], 3);
        end

        // ---------------- reset mid-RUN ----------------
        tick();
        a_in = pack(va); act_en = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_a_out", a_out, 0);
        check("abort_pos_count", pos_count, 0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | out_valid;
        end
        check("abort_no_out_valid", seen, 0);
        run_vector(vc, 1'b1, res, pos, lat);
        check("post_latency", lat, 4);
        check("post_a_out", res, pack(vc_relu));
        check("post_pos_count", pos, 4);
        release_output();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
